// File: rtl/pacman_kbd_pkg.sv
// Shared direction type and PS/2 set-2 scan codes for the pacman keyboard front end.
// Build option KEYBOARD_WASD_EN adds W/A/S/D as a second key for each direction.
package pacman_kbd_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  // One held bit per physical key; slots [7:4] are the WASD twins of [3:0].
`ifdef KEYBOARD_WASD_EN
  localparam int KEY_SLOTS = 8;
`else
  localparam int KEY_SLOTS = 4;
`endif

  // Collapse per-key held bits into per-direction held bits, indexed by dir_t.
  function automatic logic [3:0] fold_keys(input logic [KEY_SLOTS-1:0] keys);
`ifdef KEYBOARD_WASD_EN
    return keys[7:4] | keys[3:0];
`else
    return keys;
`endif
  endfunction

endpackage

// File: rtl/kbd_code_decode.sv
// Combinational scan-code classifier: direction key, Space, or ignored.
// With KEYBOARD_WASD_EN the WASD keys decode too and is_alt marks them.
module kbd_code_decode
  import pacman_kbd_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic       is_dir,
  output dir_t       dir,
`ifdef KEYBOARD_WASD_EN
  output logic       is_alt,
`endif
  output logic       is_space
);

  always_comb begin
    is_dir   = 1'b1;
    dir      = DIR_UP;
    is_space = 1'b0;
`ifdef KEYBOARD_WASD_EN
    is_alt   = 1'b0;
`endif
    case (scan_code)
      SC_UP:    dir = DIR_UP;
      SC_DOWN:  dir = DIR_DOWN;
      SC_LEFT:  dir = DIR_LEFT;
      SC_RIGHT: dir = DIR_RIGHT;
`ifdef KEYBOARD_WASD_EN
      SC_W:     begin dir = DIR_UP;    is_alt = 1'b1; end
      SC_S:     begin dir = DIR_DOWN;  is_alt = 1'b1; end
      SC_A:     begin dir = DIR_LEFT;  is_alt = 1'b1; end
      SC_D:     begin dir = DIR_RIGHT; is_alt = 1'b1; end
`endif
      SC_SPACE: begin is_dir = 1'b0; is_space = 1'b1; end
      default:  is_dir = 1'b0;
    endcase
  end

endmodule

// File: rtl/keyboard_process.sv
// Turns PS/2 key events into active-low pacman direction lines with tap stretching,
// plus a one-shot start pulse on Space. Build option KEYBOARD_WASD_EN adds WASD keys.
module keyboard_process
  import pacman_kbd_pkg::*;
#(
  parameter int HOLD_CYCLES = 2_500_000,
  parameter int CNT_W       = 22
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       valid,
  input  logic       makeBreak,
  input  logic [7:0] scan_code,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       start,
  output logic [3:0] held
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam int SLOT_W = $clog2(KEY_SLOTS);

  logic is_dir, is_space;
  dir_t dec_dir;
  logic [SLOT_W-1:0] slot;

`ifdef KEYBOARD_WASD_EN
  logic is_alt;

  kbd_code_decode u_decode (
    .scan_code (scan_code),
    .is_dir    (is_dir),
    .dir       (dec_dir),
    .is_alt    (is_alt),
    .is_space  (is_space)
  );

  assign slot = {is_alt, dec_dir};
`else
  kbd_code_decode u_decode (
    .scan_code (scan_code),
    .is_dir    (is_dir),
    .dir       (dec_dir),
    .is_space  (is_space)
  );

  assign slot = dec_dir;
`endif

  logic [KEY_SLOTS-1:0] key_held, key_held_nx;
  dir_t                 cur_dir, cur_dir_nx, best_dir;
  logic                 cur_vld, cur_vld_eff, cur_vld_nx;
  logic [CNT_W-1:0]     stretch_cnt, stretch_cnt_nx;
  logic                 space_held, space_held_nx, start_nx;
  logic [3:0]           dir_held, dir_left;

  // NOTE: blocking assignments with a default for every target first, so this
  // block stays purely combinational and infers no latch.
  always_comb begin
    key_held_nx    = key_held;
    cur_dir_nx     = cur_dir;
    space_held_nx  = space_held;
    start_nx       = 1'b0;
    stretch_cnt_nx = (stretch_cnt != '0) ? stretch_cnt - CNT_W'(1) : '0;
    dir_held       = fold_keys(key_held);

    // Expired and released: the direction drops before this cycle's event applies,
    // so a fresh press of the same key in that cycle gets a full stretch.
    cur_vld_eff = cur_vld && !(stretch_cnt == '0 && !dir_held[cur_dir]);
    cur_vld_nx  = cur_vld_eff;

    if (valid && is_dir) key_held_nx[slot] = makeBreak;
    dir_left = fold_keys(key_held_nx);

    best_dir = DIR_UP;
    for (int i = 3; i >= 0; i--)
      if (dir_left[i]) best_dir = dir_t'(2'(i));

    if (valid && is_dir) begin
      if (makeBreak) begin
        cur_vld_nx = 1'b1;
        if (!cur_vld_eff || dec_dir != cur_dir) begin
          cur_dir_nx     = dec_dir;
          stretch_cnt_nx = HOLD_LOAD;
        end
      end else if (cur_vld_eff && dec_dir == cur_dir && !dir_left[cur_dir] && dir_left != '0) begin
        cur_dir_nx     = best_dir;
        stretch_cnt_nx = HOLD_LOAD;
      end
    end

    if (valid && is_space) begin
      space_held_nx = makeBreak;
      start_nx      = makeBreak && !space_held;
    end
  end

  // NOTE: reset is synchronous, so it is simply the first branch of the clocked block.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_held    <= '0;
      cur_dir     <= DIR_UP;
      cur_vld     <= 1'b0;
      stretch_cnt <= '0;
      space_held  <= 1'b0;
      up          <= 1'b1;
      down        <= 1'b1;
      left        <= 1'b1;
      right       <= 1'b1;
      start       <= 1'b0;
      held        <= '0;
    end else begin
      key_held    <= key_held_nx;
      cur_dir     <= cur_dir_nx;
      cur_vld     <= cur_vld_nx;
      stretch_cnt <= stretch_cnt_nx;
      space_held  <= space_held_nx;
      up          <= !(cur_vld_nx && cur_dir_nx == DIR_UP);
      down        <= !(cur_vld_nx && cur_dir_nx == DIR_DOWN);
      left        <= !(cur_vld_nx && cur_dir_nx == DIR_LEFT);
      right       <= !(cur_vld_nx && cur_dir_nx == DIR_RIGHT);
      start       <= start_nx;
      held        <= {dir_left[DIR_UP], dir_left[DIR_DOWN], dir_left[DIR_LEFT], dir_left[DIR_RIGHT]};
    end
  end

endmodule
